// File: rtl/vtg_pkg.sv
// Shared types and constants for video_timing_gen: FSM states, pattern codes,
// colour-bar table and the LFSR used by the VTG_PRBS_EN pattern.
package vtg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vtg_state_e;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_HRAMP = 2'd1;
  localparam logic [1:0] PAT_VRAMP = 2'd2;
  localparam logic [1:0] PAT_PRBS  = 2'd3;

  // {r,g,b} on/off per 8-pixel bar; index 0 is the leftmost bar (white .. black)
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  localparam logic [14:0] LFSR_SEED = 15'h7FFF;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;  // x^15 + x^14 + 1

  function automatic logic [14:0] lfsr_next(input logic [14:0] s);
    return {s[13:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/vtg_pattern.sv
// Registered RGB test-pattern generator (bars, h/v ramps, PRBS when VTG_PRBS_EN).
// One cycle from de/p/l to RGB; RGB is zero whenever de is low.
module vtg_pattern
  import vtg_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        p_i,
  input  logic [5:0]        l_i,
  input  logic              de_i,
  input  logic [1:0]        sel_i,
  input  logic              frame_start_i,
  output logic [DATA_W-1:0] r_o,
  output logic [DATA_W-1:0] g_o,
  output logic [DATA_W-1:0] b_o
);

  logic [5:0]        pm1;
  logic [2:0]        bar_rgb;
  logic [DATA_W-1:0] ramp_h, ramp_v;
  logic [DATA_W-1:0] r_d, g_d, b_d;
  logic [DATA_W-1:0] r_q, g_q, b_q;

  assign pm1     = p_i - 6'd1;
  assign bar_rgb = BAR_TABLE[pm1[5:3]];
  assign ramp_h  = {p_i, {(DATA_W-6){1'b0}}};
  assign ramp_v  = {l_i, {(DATA_W-6){1'b0}}};

`ifdef VTG_PRBS_EN
  logic [14:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (frame_start_i) begin
      lfsr_d = LFSR_SEED;
    end else if (de_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start_i;
`endif

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de_i) begin
      case (sel_i)
        PAT_BARS: begin
          r_d = {DATA_W{bar_rgb[2]}};
          g_d = {DATA_W{bar_rgb[1]}};
          b_d = {DATA_W{bar_rgb[0]}};
        end
        PAT_HRAMP: begin
          r_d = ramp_h;
          g_d = ramp_h;
          b_d = ramp_h;
        end
        PAT_VRAMP: begin
          r_d = ramp_v;
          g_d = ramp_v;
          b_d = ramp_v;
        end
        PAT_PRBS: begin
`ifdef VTG_PRBS_EN
          r_d = DATA_W'(lfsr_q[9:0]);
          g_d = DATA_W'(lfsr_q[14:5]);
          b_d = DATA_W'({lfsr_q[4:0], lfsr_q[14:10]});
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r_o = r_q;
  assign g_o = g_q;
  assign b_o = b_q;

endmodule

// File: rtl/video_timing_gen.sv
// Porch-parameterised vsync/hsync/de generator with RGB test pattern; PRBS pattern via VTG_PRBS_EN.
// All outputs registered, one cycle after the h/v counters; frames always run to completion.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int PARAM_W = 6,
  parameter int CNT_W   = 9,
  parameter int DATA_W  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_en,
  input  logic [PARAM_W-1:0] i_VSW,
  input  logic [PARAM_W-1:0] i_VBP,
  input  logic [PARAM_W-1:0] i_VACT,
  input  logic [PARAM_W-1:0] i_VFP,
  input  logic [PARAM_W-1:0] i_HSW,
  input  logic [PARAM_W-1:0] i_HBP,
  input  logic [PARAM_W-1:0] i_HACT,
  input  logic [PARAM_W-1:0] i_HFP,
  input  logic [1:0]         i_pattern_sel,
  output logic               o_vsync,
  output logic               o_hsync,
  output logic               o_de,
  output logic [DATA_W-1:0]  o_r,
  output logic [DATA_W-1:0]  o_g,
  output logic [DATA_W-1:0]  o_b,
  output logic [CNT_W-1:0]   o_h_cnt,
  output logic [CNT_W-1:0]   o_v_cnt,
  output logic               o_frame_done
);

  vtg_state_e         state_q, state_d;
  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic [PARAM_W-1:0] vsw_q, vbp_q, vact_q, vfp_q;
  logic [PARAM_W-1:0] hsw_q, hbp_q, hact_q, hfp_q;
  logic [1:0]         sel_q;

  logic [CNT_W-1:0]   in_htot, in_vtot, htot, vtot, ha0, va0, ha_end, va_end;
  logic               in_ok, load, eof, frame_start;
  logic               hsync_c, vsync_c, de_c;

  logic               vsync_q, hsync_q, de_q, frame_done_q;
  logic [CNT_W-1:0]   h_cnt_q, v_cnt_q;

  // Start/restart decisions use the incoming values, since those are what get latched.
  assign in_htot = CNT_W'(i_HSW) + CNT_W'(i_HBP) + CNT_W'(i_HACT) + CNT_W'(i_HFP);
  assign in_vtot = CNT_W'(i_VSW) + CNT_W'(i_VBP) + CNT_W'(i_VACT) + CNT_W'(i_VFP);
  assign in_ok   = (in_htot != '0) && (in_vtot != '0);

  assign ha0    = CNT_W'(hsw_q) + CNT_W'(hbp_q);
  assign va0    = CNT_W'(vsw_q) + CNT_W'(vbp_q);
  assign ha_end = ha0 + CNT_W'(hact_q);
  assign va_end = va0 + CNT_W'(vact_q);
  assign htot   = ha_end + CNT_W'(hfp_q);
  assign vtot   = va_end + CNT_W'(vfp_q);

  assign eof = (state_q != IDLE) && (h_q == htot) && (v_q == vtot);

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          load = 1'b1;
          if (in_ok) begin
            state_d = RUN;
            h_d     = CNT_W'(1);
            v_d     = CNT_W'(1);
          end
        end
      end
      RUN, DRAIN: begin
        if (eof) begin
          load    = i_en;
          state_d = IDLE;
          h_d     = '0;
          v_d     = '0;
          if (i_en && in_ok) begin
            state_d = RUN;
            h_d     = CNT_W'(1);
            v_d     = CNT_W'(1);
          end
        end else begin
          if (h_q == htot) begin
            h_d = CNT_W'(1);
            v_d = v_q + CNT_W'(1);
          end else begin
            h_d = h_q + CNT_W'(1);
          end
          if (!i_en) begin
            state_d = DRAIN;
          end
        end
      end
      default: begin
        state_d = IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  assign frame_start = load && in_ok;

  assign hsync_c = (h_q != '0) && (h_q <= CNT_W'(hsw_q));
  assign vsync_c = (v_q != '0) && (v_q <= CNT_W'(vsw_q));
  assign de_c    = (h_q > ha0) && (h_q <= ha_end) && (v_q > va0) && (v_q <= va_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      h_q          <= '0;
      v_q          <= '0;
      vsw_q        <= '0;
      vbp_q        <= '0;
      vact_q       <= '0;
      vfp_q        <= '0;
      hsw_q        <= '0;
      hbp_q        <= '0;
      hact_q       <= '0;
      hfp_q        <= '0;
      sel_q        <= '0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      de_q         <= 1'b0;
      frame_done_q <= 1'b0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      if (load) begin
        vsw_q  <= i_VSW;
        vbp_q  <= i_VBP;
        vact_q <= i_VACT;
        vfp_q  <= i_VFP;
        hsw_q  <= i_HSW;
        hbp_q  <= i_HBP;
        hact_q <= i_HACT;
        hfp_q  <= i_HFP;
        sel_q  <= i_pattern_sel;
      end
      vsync_q      <= vsync_c;
      hsync_q      <= hsync_c;
      de_q         <= de_c;
      frame_done_q <= eof;
      h_cnt_q      <= h_q;
      v_cnt_q      <= v_q;
    end
  end

  vtg_pattern #(
    .DATA_W (DATA_W)
  ) u_pattern (
    .clk           (clk),
    .reset         (reset),
    .p_i           (6'(h_q - ha0)),
    .l_i           (6'(v_q - va0)),
    .de_i          (de_c),
    .sel_i         (sel_q),
    .frame_start_i (frame_start),
    .r_o           (o_r),
    .g_o           (o_g),
    .b_o           (o_b)
  );

  assign o_vsync      = vsync_q;
  assign o_hsync      = hsync_q;
  assign o_de         = de_q;
  assign o_h_cnt      = h_cnt_q;
  assign o_v_cnt      = v_cnt_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: vector table per configuration plus
// hand-written drain, re-latch, zero-parameter, mid-frame reset and PRBS sequences.
module tb_video_timing_gen;

  logic       clk = 1'b0;
  logic       reset, i_en;
  logic [5:0] i_VSW, i_VBP, i_VACT, i_VFP, i_HSW, i_HBP, i_HACT, i_HFP;
  logic [1:0] i_pattern_sel;
  logic       o_vsync, o_hsync, o_de, o_frame_done;
  logic [9:0] o_r, o_g, o_b;
  logic [8:0] o_h_cnt, o_v_cnt;

  int checks   = 0;
  int failures = 0;
  int cur_n    = 0;
  int hs_c, vs_c, de_c, fd_c, nz_c;
  int de_tot, fd_tot;
  int cur_cfg;
  logic [14:0] model;

  localparam logic [9:0] W = 10'h3FF;

  typedef struct {int hsw, hbp, hact, hfp, vsw, vbp, vact, vfp, sel;} cfg_t;
  typedef struct {int cfg; int n; logic [3:0] flags; int h; int v; logic [29:0] rgb;} vec_t;

  cfg_t cfgs[7];
  vec_t vecs[$];

  always #5 clk = ~clk;

  video_timing_gen dut (
    .clk(clk), .reset(reset), .i_en(i_en),
    .i_VSW(i_VSW), .i_VBP(i_VBP), .i_VACT(i_VACT), .i_VFP(i_VFP),
    .i_HSW(i_HSW), .i_HBP(i_HBP), .i_HACT(i_HACT), .i_HFP(i_HFP),
    .i_pattern_sel(i_pattern_sel),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
    .o_r(o_r), .o_g(o_g), .o_b(o_b),
    .o_h_cnt(o_h_cnt), .o_v_cnt(o_v_cnt), .o_frame_done(o_frame_done)
  );

  function automatic vec_t mk(input int c, input int n, input logic [3:0] f,
                              input int h, input int v, input logic [29:0] rgb);
    vec_t e;
    e.cfg = c; e.n = n; e.flags = f; e.h = h; e.v = v; e.rgb = rgb;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_cfg(input cfg_t c);
    i_HSW = 6'(c.hsw); i_HBP = 6'(c.hbp); i_HACT = 6'(c.hact); i_HFP = 6'(c.hfp);
    i_VSW = 6'(c.vsw); i_VBP = 6'(c.vbp); i_VACT = 6'(c.vact); i_VFP = 6'(c.vfp);
    i_pattern_sel = 2'(c.sel);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_en  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge where outputs show counter position (1,1): n = 0.
  task automatic start(input cfg_t c);
    apply_cfg(c);
    i_en = 1'b1;
    repeat (2) @(negedge clk);
    cur_n = 0;
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(negedge clk);
      cur_n++;
    end
  endtask

  task automatic count_window(input int cycles, output int hs, output int vs,
                              output int de, output int fd, output int nz);
    hs = 0; vs = 0; de = 0; fd = 0; nz = 0;
    for (int i = 0; i < cycles; i++) begin
      hs += int'(o_hsync);
      vs += int'(o_vsync);
      de += int'(o_de);
      fd += int'(o_frame_done);
      if ({o_r, o_g, o_b} != 30'd0) nz++;
      @(negedge clk);
      cur_n++;
    end
  endtask

  task automatic chk_vec(input vec_t e);
    string tag;
    tag = $sformatf("cfg%0d n%0d", e.cfg, e.n);
    chk({tag, " flags(hs,vs,de,fd)"}, 32'({o_hsync, o_vsync, o_de, o_frame_done}), 32'(e.flags));
    chk({tag, " h_cnt"}, 32'(o_h_cnt), e.h);
    chk({tag, " v_cnt"}, 32'(o_v_cnt), e.v);
    chk({tag, " rgb"}, 32'({o_r, o_g, o_b}), 32'(e.rgb));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " flags"}, 32'({o_hsync, o_vsync, o_de, o_frame_done}), 32'd0);
    chk({tag, " h_cnt"}, 32'(o_h_cnt), 32'd0);
    chk({tag, " v_cnt"}, 32'(o_v_cnt), 32'd0);
    chk({tag, " rgb"}, 32'({o_r, o_g, o_b}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          hsw hbp hact hfp vsw vbp vact vfp sel
    cfgs[0] = '{2, 2, 8,  2, 1, 1, 4, 1, 0};
    cfgs[1] = '{2, 2, 16, 2, 1, 1, 4, 1, 0};
    cfgs[2] = '{2, 2, 8,  2, 1, 1, 4, 1, 1};
    cfgs[3] = '{2, 2, 8,  2, 1, 1, 4, 1, 2};
    cfgs[4] = '{2, 2, 8,  2, 1, 1, 4, 1, 3};
    cfgs[5] = '{2, 2, 0,  2, 1, 1, 4, 1, 0};
    cfgs[6] = '{0, 0, 0,  0, 0, 0, 0, 0, 0};

    // Basic timing: HTOT=14, VTOT=7, de at h=5..12 on v=3..6
    vecs.push_back(mk(0,   0, 4'b1100,  1, 1, 30'd0));
    vecs.push_back(mk(0,   1, 4'b1100,  2, 1, 30'd0));
    vecs.push_back(mk(0,   2, 4'b0100,  3, 1, 30'd0));
    vecs.push_back(mk(0,  13, 4'b0100, 14, 1, 30'd0));
    vecs.push_back(mk(0,  14, 4'b1000,  1, 2, 30'd0));
    vecs.push_back(mk(0,  31, 4'b0000,  4, 3, 30'd0));
    vecs.push_back(mk(0,  32, 4'b0010,  5, 3, {W, W, W}));
    vecs.push_back(mk(0,  39, 4'b0010, 12, 3, {W, W, W}));
    vecs.push_back(mk(0,  40, 4'b0000, 13, 3, 30'd0));
    vecs.push_back(mk(0,  81, 4'b0010, 12, 6, {W, W, W}));
    vecs.push_back(mk(0,  83, 4'b0000, 14, 6, 30'd0));
    vecs.push_back(mk(0,  84, 4'b1000,  1, 7, 30'd0));
    vecs.push_back(mk(0,  96, 4'b0000, 13, 7, 30'd0));
    vecs.push_back(mk(0,  97, 4'b0001, 14, 7, 30'd0));
    vecs.push_back(mk(0,  98, 4'b1100,  1, 1, 30'd0));
    vecs.push_back(mk(0, 195, 4'b0001, 14, 7, 30'd0));
    // Colour bars, HACT=16 (HTOT=22): white for p=1..8, yellow for p=9..16
    vecs.push_back(mk(1,  47, 4'b0000,  4, 3, 30'd0));
    vecs.push_back(mk(1,  48, 4'b0010,  5, 3, {W, W, W}));
    vecs.push_back(mk(1,  55, 4'b0010, 12, 3, {W, W, W}));
    vecs.push_back(mk(1,  56, 4'b0010, 13, 3, {W, W, 10'h000}));
    vecs.push_back(mk(1,  63, 4'b0010, 20, 3, {W, W, 10'h000}));
    vecs.push_back(mk(1,  64, 4'b0000, 21, 3, 30'd0));
    // Horizontal ramp
    vecs.push_back(mk(2,  32, 4'b0010,  5, 3, {10'h010, 10'h010, 10'h010}));
    vecs.push_back(mk(2,  34, 4'b0010,  7, 3, {10'h030, 10'h030, 10'h030}));
    vecs.push_back(mk(2,  39, 4'b0010, 12, 3, {10'h080, 10'h080, 10'h080}));
    // Vertical ramp
    vecs.push_back(mk(3,  32, 4'b0010,  5, 3, {10'h010, 10'h010, 10'h010}));
    vecs.push_back(mk(3,  46, 4'b0010,  5, 4, {10'h020, 10'h020, 10'h020}));
    vecs.push_back(mk(3,  81, 4'b0010, 12, 6, {10'h040, 10'h040, 10'h040}));
    // Pattern 3: LFSR 7FFF then 7FFE, or black without the PRBS build
`ifdef VTG_PRBS_EN
    vecs.push_back(mk(4,  32, 4'b0010,  5, 3, {W, W, W}));
    vecs.push_back(mk(4,  33, 4'b0010,  6, 3, {10'h3FE, 10'h3FF, 10'h3DF}));
`else
    vecs.push_back(mk(4,  32, 4'b0010,  5, 3, 30'd0));
    vecs.push_back(mk(4,  33, 4'b0010,  6, 3, 30'd0));
`endif
    // HACT=0 (HTOT=6): syncs run, de never
    vecs.push_back(mk(5,   0, 4'b1100,  1, 1, 30'd0));
    vecs.push_back(mk(5,   4, 4'b0100,  5, 1, 30'd0));
    vecs.push_back(mk(5,  16, 4'b0000,  5, 3, 30'd0));
    vecs.push_back(mk(5,  41, 4'b0001,  6, 7, 30'd0));
    // All-zero parameters: stays idle
    vecs.push_back(mk(6,   0, 4'b0000,  0, 0, 30'd0));
    vecs.push_back(mk(6,  10, 4'b0000,  0, 0, 30'd0));

    reset = 1'b1;
    i_en  = 1'b0;
    apply_cfg(cfgs[6]);
    #12;
    chk_idle("reset");
    do_reset();

    cur_cfg = -1;
    foreach (vecs[i]) begin
      if (vecs[i].cfg != cur_cfg) begin
        cur_cfg = vecs[i].cfg;
        do_reset();
        start(cfgs[cur_cfg]);
      end
      while (cur_n < vecs[i].n) step(1);
      chk_vec(vecs[i]);
    end

    // Latency from i_en and per-frame activity counts
    do_reset();
    apply_cfg(cfgs[0]);
    i_en = 1'b1;
    @(negedge clk);
    chk("latency N+1 hsync", 32'(o_hsync), 32'd0);
    chk("latency N+1 h_cnt", 32'(o_h_cnt), 32'd0);
    @(negedge clk);
    chk("latency N+2 hs/vs", 32'({o_hsync, o_vsync}), 32'd3);
    cur_n = 0;
    count_window(98, hs_c, vs_c, de_c, fd_c, nz_c);
    chk("frame hsync count", hs_c, 32'd14);
    chk("frame vsync count", vs_c, 32'd14);
    chk("frame de count", de_c, 32'd32);
    chk("frame done count", fd_c, 32'd1);
    chk("frame bars nonzero count", nz_c, 32'd32);

    // Drain: drop i_en mid-frame, frame still completes
    do_reset();
    start(cfgs[0]);
    count_window(20, hs_c, vs_c, de_c, fd_c, nz_c);
    de_tot = de_c; fd_tot = fd_c;
    i_en = 1'b0;
    count_window(78, hs_c, vs_c, de_c, fd_c, nz_c);
    de_tot += de_c; fd_tot += fd_c;
    chk("drain de count", de_tot, 32'd32);
    chk("drain frame_done count", fd_tot, 32'd1);
    chk_idle("drain end");
    step(5);
    chk_idle("drain idle");

    // HACT change mid-frame applies from the next frame only
    do_reset();
    start(cfgs[0]);
    count_window(20, hs_c, vs_c, de_c, fd_c, nz_c);
    de_tot = de_c;
    i_HACT = 6'd4;
    count_window(78, hs_c, vs_c, de_c, fd_c, nz_c);
    de_tot += de_c;
    chk("relatch old frame de", de_tot, 32'd32);
    count_window(70, hs_c, vs_c, de_c, fd_c, nz_c);
    chk("relatch new frame de", de_c, 32'd16);
    chk("relatch new frame done", fd_c, 32'd1);
    chk("relatch new frame hsync", hs_c, 32'd14);
    chk("relatch wrap h_cnt", 32'(o_h_cnt), 32'd1);
    chk("relatch wrap v_cnt", 32'(o_v_cnt), 32'd1);

    // HACT=0 over a whole frame
    do_reset();
    start(cfgs[5]);
    count_window(42, hs_c, vs_c, de_c, fd_c, nz_c);
    chk("hact0 hsync count", hs_c, 32'd14);
    chk("hact0 vsync count", vs_c, 32'd6);
    chk("hact0 de count", de_c, 32'd0);
    chk("hact0 frame done", fd_c, 32'd1);

    // Zero totals re-evaluated each cycle: valid parameters start immediately
    do_reset();
    apply_cfg(cfgs[6]);
    i_en = 1'b1;
    step(6);
    chk_idle("zero params");
    apply_cfg(cfgs[0]);
    @(negedge clk);
    chk("zero->valid N+1 hsync", 32'(o_hsync), 32'd0);
    @(negedge clk);
    chk("zero->valid N+2 hsync", 32'(o_hsync), 32'd1);
    chk("zero->valid N+2 h_cnt", 32'(o_h_cnt), 32'd1);

    // Reset while counters are at h=7, v=3
    do_reset();
    start(cfgs[0]);
    step(33);
    chk("pre-reset h_cnt", 32'(o_h_cnt), 32'd6);
    chk("pre-reset v_cnt", 32'(o_v_cnt), 32'd3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("mid-frame reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset +1 hsync", 32'(o_hsync), 32'd0);
    @(negedge clk);
    chk("post-reset +2 hsync", 32'(o_hsync), 32'd1);
    chk("post-reset +2 h_cnt", 32'(o_h_cnt), 32'd1);

    // Pattern 3 over two frames
    do_reset();
    start(cfgs[4]);
`ifdef VTG_PRBS_EN
    model = 15'h7FFF;
    for (int i = 0; i < 196; i++) begin
      if (o_h_cnt == 9'd1 && o_v_cnt == 9'd1) model = 15'h7FFF;
      if (o_de) begin
        chk($sformatf("prbs n%0d rgb", cur_n), 32'({o_r, o_g, o_b}),
            32'({model[9:0], model[14:5], model[4:0], model[14:10]}));
        model = {model[13:0], model[14] ^ model[13]};
      end
      step(1);
    end
`else
    count_window(98, hs_c, vs_c, de_c, fd_c, nz_c);
    chk("pattern3 de count", de_c, 32'd32);
    chk("pattern3 nonzero rgb", nz_c, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
